traffic_generator_gmii_regs: RTL and testbench

//  AXI4-Lite register responder for traffic_generator_gmii. Answers PS initiator reads/writes,

---
 rtl/traffic_generator_gmii_regs.sv | 212 +++++++++++++++++++++
 tb/tb_traffic_generator_gmii_regs.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_generator_gmii_regs.sv
// AXI4-Lite register block for the GMII traffic generator: control/IFG/frame-size config,
// template RAM loader through a data port, and 64-bit TX counters with lo-then-hi snapshot.
//   state  | meaning
//   W_IDLE | collecting AW and W, either order, each held once accepted
//   W_RESP | register updated, bvalid held until bready
//   R_IDLE | arready high, waiting for AR
//   R_DATA | rdata/rvalid held until rready
module traffic_generator_gmii_regs #(
  parameter logic [31:0] IP_ID       = 32'h0A17_0001,
  parameter int          TMPL_WORDS  = 64,
  parameter logic [15:0] IFG_RESET   = 16'd12,
  parameter logic [15:0] FSIZE_RESET = 16'd72,
  localparam int         TW          = $clog2(TMPL_WORDS)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [15:0]   s_axi_awaddr,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [31:0]   s_axi_wdata,
  input  logic [3:0]    s_axi_wstrb,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  output logic [1:0]    s_axi_bresp,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  input  logic [15:0]   s_axi_araddr,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  output logic [31:0]   s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  output logic          gen_enable,
  output logic [15:0]   gen_ifg,
  output logic [15:0]   gen_frame_size,
  input  logic [TW-1:0] tmpl_raddr,
  output logic [31:0]   tmpl_rdata,
  input  logic          gen_busy,
  input  logic [63:0]   cnt_frames,
  input  logic [63:0]   cnt_octets
);

  localparam logic [15:0] A_ID      = 16'h0000;
  localparam logic [15:0] A_STATUS  = 16'h0004;
  localparam logic [15:0] A_FLIP    = 16'h000C;
  localparam logic [15:0] A_CONTROL = 16'h0010;
  localparam logic [15:0] A_IFG     = 16'h0014;
  localparam logic [15:0] A_FR_LO   = 16'h0020;
  localparam logic [15:0] A_FR_HI   = 16'h0024;
  localparam logic [15:0] A_OC_LO   = 16'h0028;
  localparam logic [15:0] A_OC_HI   = 16'h002C;
  localparam logic [15:0] A_FSIZE   = 16'h0044;
  localparam logic [15:0] A_WPTR    = 16'h0048;
  localparam logic [15:0] A_TDATA   = 16'h0050;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t       wstate;
  rstate_t       rstate;
  logic          aw_held, w_held;
  logic [15:0]   aw_addr_q;
  logic [31:0]   w_data_q;
  logic          aw_fire, w_fire, wr_go, tmpl_we;
  logic [15:0]   wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   flip_q;
  logic [TW-1:0] wptr;
  logic [31:0]   fr_shadow, oc_shadow;
  logic [31:0]   rd_mux;
  logic [31:0]   tmpl_mem [TMPL_WORDS];
  logic          unused_wstrb;

  assign unused_wstrb = ^s_axi_wstrb;
  assign s_axi_bresp  = 2'b00;
  assign s_axi_rresp  = 2'b00;

  // A channel already accepted is taken from its holding register, otherwise from the bus.
  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid & s_axi_wready;
  assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held ? w_data_q : s_axi_wdata;
  assign wr_go   = (wstate == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
  assign tmpl_we = wr_go & ~areset & (wr_addr == A_TDATA);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held       <= 1'b1;
            aw_addr_q     <= s_axi_awaddr;
            s_axi_awready <= 1'b0;
          end
          if (w_fire) begin
            w_held       <= 1'b1;
            w_data_q     <= s_axi_wdata;
            s_axi_wready <= 1'b0;
          end
          if (wr_go) begin
            wstate        <= W_RESP;
            s_axi_bvalid  <= 1'b1;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            wstate        <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      gen_enable     <= 1'b0;
      gen_ifg        <= IFG_RESET;
      gen_frame_size <= FSIZE_RESET;
      flip_q         <= '0;
      wptr           <= '0;
    end else if (wr_go) begin
      case (wr_addr)
        A_FLIP:    flip_q     <= wr_data;
        A_CONTROL: gen_enable <= wr_data[0];
        A_IFG:     gen_ifg    <= wr_data[15:0];
        // A new frame size means a new template; restart loading at word 0.
        A_FSIZE: begin
          gen_frame_size <= wr_data[15:0];
          wptr           <= '0;
        end
        A_TDATA:   wptr       <= wptr + 1'b1;
        default:   ;
      endcase
    end
  end

  // Template RAM: no reset, read-before-write on address collision.
  always_ff @(posedge aclk) begin
    if (tmpl_we) tmpl_mem[wptr] <= wr_data;
    tmpl_rdata <= tmpl_mem[tmpl_raddr];
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr)
      A_ID:      rd_mux = IP_ID;
      A_STATUS:  rd_mux = {31'b0, gen_busy};
      A_FLIP:    rd_mux = ~flip_q;
      A_CONTROL: rd_mux = {31'b0, gen_enable};
      A_IFG:     rd_mux = {16'b0, gen_ifg};
      A_FR_LO:   rd_mux = cnt_frames[31:0];
      A_FR_HI:   rd_mux = fr_shadow;
      A_OC_LO:   rd_mux = cnt_octets[31:0];
      A_OC_HI:   rd_mux = oc_shadow;
      A_FSIZE:   rd_mux = {16'b0, gen_frame_size};
      A_WPTR:    rd_mux = {{(32-TW){1'b0}}, wptr};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      fr_shadow     <= '0;
      oc_shadow     <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            rstate        <= R_DATA;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_mux;
            // Lo read freezes the matching hi word so a following hi read is coherent.
            if (s_axi_araddr == A_FR_LO) fr_shadow <= cnt_frames[63:32];
            if (s_axi_araddr == A_OC_LO) oc_shadow <= cnt_octets[63:32];
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rstate        <= R_IDLE;
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_generator_gmii_regs.sv
// Bench for traffic_generator_gmii_regs: AXI4-Lite register access, template loading,
// counter snapshots, handshake ordering and mid-transaction reset.
module tb_traffic_generator_gmii_regs;
  localparam int TMPL_WORDS = 64;
  localparam int TW = $clog2(TMPL_WORDS);
  localparam logic [31:0] IP_ID = 32'h0A17_0001;

  logic          aclk = 1'b0;
  logic          areset;
  logic [15:0]   s_axi_awaddr;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [31:0]   s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [15:0]   s_axi_araddr;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic          gen_enable;
  logic [15:0]   gen_ifg;
  logic [15:0]   gen_frame_size;
  logic [TW-1:0] tmpl_raddr;
  logic [31:0]   tmpl_rdata;
  logic          gen_busy;
  logic [63:0]   cnt_frames;
  logic [63:0]   cnt_octets;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [$];

  traffic_generator_gmii_regs dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .gen_enable(gen_enable),
    .gen_ifg(gen_ifg), .gen_frame_size(gen_frame_size), .tmpl_raddr(tmpl_raddr),
    .tmpl_rdata(tmpl_rdata), .gen_busy(gen_busy), .cnt_frames(cnt_frames), .cnt_octets(cnt_octets)
  );

  always #5 aclk = ~aclk;

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, output logic [1:0] resp);
    bit aw_hs, w_hs;
    int n;
    @(negedge aclk);
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid = 1'b0;
      n++;
    end
    while (!s_axi_bvalid && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    resp = s_axi_bresp;
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL write_timeout addr %h: no bvalid within 50 cycles", a);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      resp = 2'bxx;
    end
    @(posedge aclk); #1;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    while (!s_axi_rvalid && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    d = s_axi_rdata; resp = s_axi_rresp;
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL read_timeout addr %h: no rvalid within 50 cycles", a);
      d = 'x;
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    tests_run++;
    got = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, gen_enable, 26'b0};
    if (got !== {6'b111000, 26'b0}) begin
      tests_failed++;
      $display("FAIL reset_handshake: got %h exp %h", got, {6'b111000, 26'b0});
    end
    tests_run++;
    if ({gen_ifg, gen_frame_size} !== {16'd12, 16'd72}) begin
      tests_failed++;
      $display("FAIL reset_cfg: got %h exp %h", {gen_ifg, gen_frame_size}, {16'd12, 16'd72});
    end
    tests_run++;
    if ({s_axi_rdata, s_axi_rresp, s_axi_bresp} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h exp 0", {s_axi_rdata, s_axi_rresp, s_axi_bresp});
    end
  endtask

  task automatic test_defaults();
    logic [15:0] addrs [7] = '{16'h0000, 16'h0014, 16'h0044, 16'h0004, 16'h003C, 16'h000C, 16'h0048};
    logic [31:0] d, e;
    logic [1:0] r;
    gen_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: exp_q.push_back(IP_ID);
        1: exp_q.push_back(32'h0000_000C);
        2: exp_q.push_back(32'h0000_0048);
        3: exp_q.push_back(32'h0000_0001);
        4: exp_q.push_back(32'h0);
        5: exp_q.push_back(32'hFFFF_FFFF);
        default: exp_q.push_back(32'h0);
      endcase
      axi_read(addrs[i], d, r);
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL default_read %h: got %h resp %b exp %h resp 00", addrs[i], d, r, e);
      end
    end
    gen_busy = 1'b0;
  endtask

  task automatic test_flip_and_control();
    logic [31:0] d, e;
    logic [1:0] r;
    axi_write(16'h000C, 32'h1234_5678, r);
    tests_run++;
    if (r !== 2'b00) begin
      tests_failed++;
      $display("FAIL flip_bresp: got %b exp 00", r);
    end
    exp_q.push_back(32'hEDCB_A987);
    axi_read(16'h000C, d, r);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL flip_read: got %h exp %h", d, e); end
    axi_write(16'h0010, 32'h0000_0001, r);
    tests_run++;
    if (gen_enable !== 1'b1) begin tests_failed++; $display("FAIL control_enable: got %b exp 1", gen_enable); end
    axi_write(16'h0014, 32'hABCD_0060, r);
    tests_run++;
    if (gen_ifg !== 16'h0060) begin tests_failed++; $display("FAIL ifg_write: got %h exp 0060", gen_ifg); end
    axi_write(16'h0000, 32'hDEAD_BEEF, r);
    axi_write(16'h0070, 32'hDEAD_BEEF, r);
    tests_run++;
    if (r !== 2'b00) begin tests_failed++; $display("FAIL unmapped_bresp: got %b exp 00", r); end
    exp_q.push_back(IP_ID);
    axi_read(16'h0000, d, r);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL ro_id_write: got %h exp %h", d, e); end
  endtask

  task automatic test_template();
    logic [31:0] words [18] = '{32'h5555_5555, 32'hD555_5555, 32'h0102_0304, 32'h0506_0708,
      32'h090A_0B0C, 32'h0D0E_0F10, 32'h1112_1314, 32'h1516_1718, 32'h191A_1B1C, 32'h1D1E_1F20,
      32'h2122_2324, 32'h2526_2728, 32'h292A_2B2C, 32'h2D2E_2F30, 32'h3132_3334, 32'h3536_3738,
      32'h393A_3B3C, 32'h344C_A062};
    logic [31:0] d, e;
    logic [1:0] r;
    axi_write(16'h0044, 32'h0000_0048, r);
    tests_run++;
    if (gen_frame_size !== 16'h0048) begin tests_failed++; $display("FAIL fsize_write: got %h exp 0048", gen_frame_size); end
    for (int i = 0; i < 18; i++) axi_write(16'h0050, words[i], r);
    exp_q.push_back(32'd18);
    axi_read(16'h0048, d, r);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL tmpl_wptr18: got %h exp %h", d, e); end
    for (int k = 0; k < 3; k++) begin
      logic [TW-1:0] ra;
      ra = (k == 0) ? TW'(2) : (k == 1) ? TW'(17) : TW'(0);
      @(negedge aclk);
      tmpl_raddr = ra;
      exp_q.push_back(words[ra]);
      @(posedge aclk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (tmpl_rdata !== e) begin tests_failed++; $display("FAIL tmpl_read %0d: got %h exp %h", ra, tmpl_rdata, e); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    logic [1:0] r;
    axi_write(16'h0044, 32'h0000_0100, r);
    exp_q.push_back(32'd0);
    axi_read(16'h0048, d, r);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL fsize_clears_wptr: got %h exp %h", d, e); end
    for (int i = 0; i <= TMPL_WORDS; i++) axi_write(16'h0050, 32'hA000_0000 + i, r);
    exp_q.push_back(32'd1);
    axi_read(16'h0048, d, r);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL wrap_wptr: got %h exp %h", d, e); end
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      tmpl_raddr = TW'(k);
      exp_q.push_back(k == 0 ? 32'hA000_0000 + TMPL_WORDS : 32'hA000_0001);
      @(posedge aclk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (tmpl_rdata !== e) begin tests_failed++; $display("FAIL wrap_ram %0d: got %h exp %h", k, tmpl_rdata, e); end
    end
  endtask

  task automatic test_counter_snapshot();
    logic [15:0] addrs [6] = '{16'h0020, 16'h0024, 16'h0020, 16'h002C, 16'h0028, 16'h002C};
    logic [31:0] d, e;
    logic [1:0] r;
    cnt_frames = 64'h1_FFFF_FFFF;
    cnt_octets = 64'h5_0000_0010;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: exp_q.push_back(32'hFFFF_FFFF);
        1: exp_q.push_back(32'h0000_0001);
        2: exp_q.push_back(32'h0000_0000);
        3: exp_q.push_back(32'h0000_0000);
        4: exp_q.push_back(32'h0000_0010);
        default: exp_q.push_back(32'h0000_0005);
      endcase
      axi_read(addrs[i], d, r);
      if (i == 0) cnt_frames = 64'h2_0000_0000;
      if (i == 4) cnt_octets = 64'h9_0000_0000;
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e) begin tests_failed++; $display("FAIL snapshot step %0d addr %h: got %h exp %h", i, addrs[i], d, e); end
    end
  endtask

  task automatic test_w_before_aw();
    int bcnt, extra;
    @(negedge aclk);
    s_axi_wdata = 32'h0; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0;
    tests_run++;
    if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL w_held: got wready %b bvalid %b exp 0 0", s_axi_wready, s_axi_bvalid);
    end
    repeat (4) @(posedge aclk);
    #1;
    s_axi_awaddr = 16'h0010; s_axi_awvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    bcnt = 0;
    repeat (3) begin
      @(negedge aclk);
      if (s_axi_bvalid) bcnt++;
    end
    s_axi_bready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge aclk);
      if (s_axi_bvalid) extra++;
    end
    tests_run++;
    if (bcnt !== 3 || extra !== 0) begin
      tests_failed++;
      $display("FAIL bvalid_hold: got %0d then %0d cycles exp 3 then 0", bcnt, extra);
    end
    tests_run++;
    if ({gen_enable, s_axi_awready, s_axi_wready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL w_before_aw_update: got %b exp 011", {gen_enable, s_axi_awready, s_axi_wready});
    end
  endtask

  task automatic test_concurrent_rw();
    logic [31:0] d;
    int n;
    @(negedge aclk);
    s_axi_araddr = 16'h0014; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    s_axi_awaddr = 16'h0014; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0099; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    exp_q.push_back(32'h0000_0060);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    d = s_axi_rdata;
    @(posedge aclk); #1;
    tests_run++;
    if (d !== exp_q[0]) begin tests_failed++; $display("FAIL concurrent_read: got %h exp %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    tests_run++;
    if (gen_ifg !== 16'h0099) begin tests_failed++; $display("FAIL concurrent_write: got %h exp 0099", gen_ifg); end
  endtask

  task automatic test_reset_mid_ar();
    logic [31:0] d, e;
    logic [1:0] r;
    int seen;
    @(negedge aclk);
    s_axi_araddr = 16'h0000; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0; s_axi_arvalid = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge aclk);
      if (s_axi_rvalid) seen++;
    end
    tests_run++;
    if (seen !== 0 || s_axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_ar: got rvalid %0d cycles arready %b exp 0 cycles arready 1", seen, s_axi_arready);
    end
    tests_run++;
    if ({gen_ifg, 15'b0, gen_enable} !== {16'd12, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid_cfg: got %h exp %h", {gen_ifg, 15'b0, gen_enable}, {16'd12, 16'd0});
    end
    exp_q.push_back(IP_ID);
    axi_read(16'h0000, d, r);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL read_after_reset: got %h exp %h", d, e); end
  endtask

  initial begin
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; tmpl_raddr = '0; gen_busy = 1'b0; cnt_frames = '0; cnt_octets = '0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    test_reset();
    test_defaults();
    test_flip_and_control();
    test_template();
    test_wrap();
    test_counter_snapshot();
    test_w_before_aw();
    test_concurrent_rw();
    test_reset_mid_ar();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
